// File: rtl/param_ram_if.sv
// Handshake bundle for param_ram: read port, write port and clear-engine status.
interface param_ram_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
);
  logic                  rd;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;
  logic                  rd_err;
  logic                  wr;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_err;
  logic                  clr;
  logic                  busy;
  logic                  clr_done;

  modport master (
    output rd, rd_addr, wr, wr_addr, wr_data, clr,
    input  rd_data, rd_valid, rd_err, wr_err, busy, clr_done
  );

  modport slave (
    input  rd, rd_addr, wr, wr_addr, wr_data, clr,
    output rd_data, rd_valid, rd_err, wr_err, busy, clr_done
  );
endinterface

// File: rtl/param_ram.sv
// Parametrised register-file RAM: 1-cycle write, registered read with valid/error
// pulses, selectable read-during-write policy and a one-entry-per-cycle clear engine.
module param_ram #(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 8,
  parameter int DEPTH       = 8,
  parameter bit WRITE_FIRST = 1'b1
) (
  input  logic        clk_system,
  input  logic        reset_n,
  param_ram_if.slave  bus
);
  localparam int                IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // One extra bit so DEPTH == 2**ADDR_WIDTH still compares correctly.
  localparam logic [ADDR_WIDTH:0] DEPTH_A = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [IW-1:0]     LAST    = IW'(DEPTH - 1);

  typedef enum logic {IDLE, CLEAR} state_e;

  state_e                               state_q, state_d;
  logic [DEPTH-1:0][DATA_WIDTH-1:0]     mem_q, mem_d;
  logic [IW-1:0]                        cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]                rd_data_q, rd_data_d;
  logic                                 rd_valid_q, rd_valid_d;
  logic                                 rd_err_q, rd_err_d;
  logic                                 wr_err_q, wr_err_d;
  logic                                 clr_done_q, clr_done_d;
  logic                                 busy_q;

  logic          rd_in, wr_in, wr_ok, fwd;
  logic [IW-1:0] rd_idx, wr_idx;

  assign rd_in  = {1'b0, bus.rd_addr} < DEPTH_A;
  assign wr_in  = {1'b0, bus.wr_addr} < DEPTH_A;
  assign rd_idx = bus.rd_addr[IW-1:0];
  assign wr_idx = bus.wr_addr[IW-1:0];
  assign wr_ok  = (state_q == IDLE) && bus.wr && wr_in;
  assign fwd    = WRITE_FIRST && wr_ok && (bus.wr_addr == bus.rd_addr);

  always_comb begin
    state_d    = state_q;
    mem_d      = mem_q;
    cnt_d      = cnt_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = bus.rd;
    rd_err_d   = 1'b0;
    wr_err_d   = 1'b0;
    clr_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (wr_ok) mem_d[wr_idx] = bus.wr_data;
        wr_err_d = bus.wr && !wr_in;
        if (bus.rd) begin
          if (rd_in) rd_data_d = fwd ? bus.wr_data : mem_q[rd_idx];
          else       rd_err_d  = 1'b1;
        end
        // clr still lets this cycle's rd/wr complete before the sweep starts.
        if (bus.clr) state_d = CLEAR;
      end
      CLEAR: begin
        mem_d[cnt_q] = '0;
        wr_err_d     = bus.wr;
        rd_err_d     = bus.rd;
        if (cnt_q == LAST) begin
          state_d    = IDLE;
          cnt_d      = '0;
          clr_done_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_system or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      mem_q      <= '0;
      cnt_q      <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_err_q   <= 1'b0;
      wr_err_q   <= 1'b0;
      clr_done_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      mem_q      <= mem_d;
      cnt_q      <= cnt_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      rd_err_q   <= rd_err_d;
      wr_err_q   <= wr_err_d;
      clr_done_q <= clr_done_d;
      busy_q     <= (state_d == CLEAR);
    end
  end

  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_err   = rd_err_q;
  assign bus.wr_err   = wr_err_q;
  assign bus.busy     = busy_q;
  assign bus.clr_done = clr_done_q;
endmodule

// File: tb/tb_param_ram.sv
// Drives three param_ram builds (write-first 8x8, read-first 8x8, write-first 16x32)
// from one stimulus stream and compares every output each cycle against a model.
module tb_param_ram;
  logic clk_system = 1'b0;
  always #5 clk_system = ~clk_system;

  logic        reset_n;
  logic        rd, wr, clr;
  logic [7:0]  ra, wa;
  logic [15:0] wd;

  param_ram_if #(.DATA_WIDTH(8),  .ADDR_WIDTH(8)) ifa ();
  param_ram_if #(.DATA_WIDTH(8),  .ADDR_WIDTH(8)) ifb ();
  param_ram_if #(.DATA_WIDTH(16), .ADDR_WIDTH(8)) ifc ();

  assign ifa.rd = rd; assign ifa.rd_addr = ra; assign ifa.wr = wr;
  assign ifa.wr_addr = wa; assign ifa.wr_data = wd[7:0]; assign ifa.clr = clr;
  assign ifb.rd = rd; assign ifb.rd_addr = ra; assign ifb.wr = wr;
  assign ifb.wr_addr = wa; assign ifb.wr_data = wd[7:0]; assign ifb.clr = clr;
  assign ifc.rd = rd; assign ifc.rd_addr = ra; assign ifc.wr = wr;
  assign ifc.wr_addr = wa; assign ifc.wr_data = wd; assign ifc.clr = clr;

  param_ram #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .DEPTH(8), .WRITE_FIRST(1'b1))
    u_a (.clk_system(clk_system), .reset_n(reset_n), .bus(ifa));
  param_ram #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .DEPTH(8), .WRITE_FIRST(1'b0))
    u_b (.clk_system(clk_system), .reset_n(reset_n), .bus(ifb));
  param_ram #(.DATA_WIDTH(16), .ADDR_WIDTH(8), .DEPTH(32), .WRITE_FIRST(1'b1))
    u_c (.clk_system(clk_system), .reset_n(reset_n), .bus(ifc));

  int n_tests = 0, n_fail = 0;

  // Reference state per build.
  int          depth [3] = '{8, 8, 32};
  bit          wf    [3] = '{1'b1, 1'b0, 1'b1};
  logic [15:0] mask  [3] = '{16'h00FF, 16'h00FF, 16'hFFFF};
  logic [15:0] mem   [3][32];
  int          clr_left [3];
  logic [15:0] e_data [3];
  logic        e_vld [3], e_rerr [3], e_werr [3], e_busy [3], e_done [3];

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t got=%0h exp=%0h", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      for (int a = 0; a < 32; a++) mem[i][a] = '0;
      clr_left[i] = 0; e_data[i] = '0;
      e_vld[i] = 0; e_rerr[i] = 0; e_werr[i] = 0; e_busy[i] = 0; e_done[i] = 0;
    end
  endtask

  // Effect of the current inputs at the coming rising edge.
  task automatic model_step();
    for (int i = 0; i < 3; i++) begin
      e_vld[i] = rd; e_rerr[i] = 0; e_werr[i] = 0; e_done[i] = 0;
      if (clr_left[i] > 0) begin
        mem[i][depth[i] - clr_left[i]] = '0;
        clr_left[i]--;
        e_done[i] = (clr_left[i] == 0);
        e_werr[i] = wr;
        e_rerr[i] = rd;
      end else begin
        logic [15:0] old;
        old = (int'(ra) < depth[i]) ? mem[i][ra] : 16'h0;
        if (wr && int'(wa) < depth[i]) mem[i][wa] = wd & mask[i];
        else                           e_werr[i] = wr;
        if (rd) begin
          if (int'(ra) < depth[i]) e_data[i] = (wf[i] && wr && wa == ra) ? (wd & mask[i]) : old;
          else                     e_rerr[i] = 1;
        end
        if (clr) clr_left[i] = depth[i];
      end
      e_busy[i] = clr_left[i] > 0;
    end
  endtask

  task automatic chk_inst(string n, int i, logic [15:0] d, logic v, logic re,
                          logic we, logic b, logic cd);
    chk({n, ".rd_data"},  {16'h0, d}, {16'h0, e_data[i]});
    chk({n, ".rd_valid"}, {31'h0, v},  {31'h0, e_vld[i]});
    chk({n, ".rd_err"},   {31'h0, re}, {31'h0, e_rerr[i]});
    chk({n, ".wr_err"},   {31'h0, we}, {31'h0, e_werr[i]});
    chk({n, ".busy"},     {31'h0, b},  {31'h0, e_busy[i]});
    chk({n, ".clr_done"}, {31'h0, cd}, {31'h0, e_done[i]});
  endtask

  task automatic check_all();
    chk_inst("a", 0, {8'h0, ifa.rd_data}, ifa.rd_valid, ifa.rd_err, ifa.wr_err, ifa.busy, ifa.clr_done);
    chk_inst("b", 1, {8'h0, ifb.rd_data}, ifb.rd_valid, ifb.rd_err, ifb.wr_err, ifb.busy, ifb.clr_done);
    chk_inst("c", 2, ifc.rd_data,         ifc.rd_valid, ifc.rd_err, ifc.wr_err, ifc.busy, ifc.clr_done);
  endtask

  task automatic cyc(logic r, logic [7:0] rad, logic w, logic [7:0] wad,
                     logic [15:0] wdat, logic c);
    rd = r; ra = rad; wr = w; wa = wad; wd = wdat; clr = c;
    model_step();
    @(posedge clk_system);
    @(negedge clk_system);
    check_all();
  endtask

  task automatic idle(int n);
    for (int k = 0; k < n; k++) cyc(0, 0, 0, 0, 0, 0);
  endtask

  task automatic read_all();
    for (int a = 0; a < 32; a++) cyc(1, 8'(a), 0, 0, 0, 0);
  endtask

  initial begin
    int busy_a, busy_c;
    reset_n = 0; rd = 0; wr = 0; clr = 0; ra = 0; wa = 0; wd = 0;
    model_reset();
    @(negedge clk_system);
    check_all();
    reset_n = 1;

    // Fresh contents read back as zero.
    for (int a = 0; a < 8; a++) cyc(1, 8'(a), 0, 0, 0, 0);

    cyc(0, 0, 1, 3, 16'h00A5, 0);
    cyc(0, 0, 1, 7, 16'h005A, 0);
    cyc(1, 3, 0, 0, 0, 0);
    chk("rd3_a", {24'h0, ifa.rd_data}, 32'hA5);
    cyc(1, 7, 0, 0, 0, 0);
    chk("rd7_a", {24'h0, ifa.rd_data}, 32'h5A);

    // Read-during-write on the same address.
    cyc(0, 0, 1, 2, 16'h0011, 0);
    cyc(1, 2, 1, 2, 16'h003C, 0);
    chk("rdw_wf1", {24'h0, ifa.rd_data}, 32'h3C);
    chk("rdw_wf0", {24'h0, ifb.rd_data}, 32'h11);
    cyc(1, 2, 0, 0, 0, 0);
    chk("rdw_after_wf0", {24'h0, ifb.rd_data}, 32'h3C);

    cyc(0, 0, 1, 9, 16'h00EE, 0);
    chk("wr_oor_err", {31'h0, ifa.wr_err}, 32'h1);
    cyc(1, 8, 0, 0, 0, 0);
    chk("rd_oor_err", {31'h0, ifa.rd_err}, 32'h1);

    // Full clear with rejected traffic part-way through.
    for (int a = 0; a < 32; a++) cyc(0, 0, 1, 8'(a), 16'hFFFF, 0);
    busy_a = 0; busy_c = 0;
    cyc(0, 0, 0, 0, 0, 1);
    busy_a += int'(ifa.busy); busy_c += int'(ifc.busy);
    for (int k = 0; k < 34; k++) begin
      if (k == 3) cyc(1, 2, 1, 1, 16'h1234, 1);
      else        cyc(0, 0, 0, 0, 0, 0);
      busy_a += int'(ifa.busy); busy_c += int'(ifc.busy);
    end
    chk("clr_len_a", 32'(busy_a), 32'd8);
    chk("clr_len_c", 32'(busy_c), 32'd32);
    read_all();

    // Reset partway through a clear.
    for (int a = 0; a < 32; a++) cyc(0, 0, 1, 8'(a), 16'($urandom), 0);
    cyc(0, 0, 0, 0, 0, 1);
    idle(2);
    reset_n = 0;
    #1;
    model_reset();
    check_all();
    chk("rst_busy_c", {31'h0, ifc.busy}, 32'h0);
    @(negedge clk_system);
    reset_n = 1;
    idle(3);
    read_all();

    // Random traffic.
    for (int k = 0; k < 3000; k++)
      cyc(1'($urandom_range(0, 1)), 8'($urandom_range(0, 40)),
          1'($urandom_range(0, 1)), 8'($urandom_range(0, 40)),
          16'($urandom), 1'($urandom_range(0, 63) == 0));
    idle(40);
    read_all();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/param_ram.md
Name: param_ram

Overview:
- Parametrised successor to the 8x8 register-file RAM.
- Separate single-cycle write port and registered read port, with configurable data width, depth and address width.
- Adds read-valid and error handshakes, a selectable read-during-write policy, and a sequential clear engine.
- Used as a scratch or register store between the sensor/PWM logic and the flight-control state machines.

Parameters:
- DATA_WIDTH, 8, width of each entry and of the data ports.
- ADDR_WIDTH, 8, width of the rd_addr and wr_addr ports.
- DEPTH, 8, number of entries. Legal range 1..2^ADDR_WIDTH.
- WRITE_FIRST, 1, read-during-write policy for the same address. 1 = read returns the new data; 0 = read returns the old data.

Ports:
- clk_system  in  1  system clock; all logic acts on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- rd  in  1  read request, sampled each cycle.
- rd_addr  in  ADDR_WIDTH  read address.
- rd_data  out  DATA_WIDTH  registered read data.
- rd_valid  out  1  one-cycle pulse; rd_data was updated or the read was rejected.
- rd_err  out  1  one-cycle pulse with rd_valid; read was out of range or blocked.
- wr  in  1  write request.
- wr_addr  in  ADDR_WIDTH  write address.
- wr_data  in  DATA_WIDTH  write data.
- wr_err  out  1  one-cycle pulse in the cycle after a rejected write.
- clr  in  1  start-clear request.
- busy  out  1  high while the clear engine runs.
- clr_done  out  1  one-cycle pulse when the clear completes.

Behaviour:
- Reset (asynchronous, reset_n low): all entries, rd_data, rd_valid, rd_err, wr_err, busy and clr_done go to 0; FSM goes to IDLE; clear counter goes to 0. Reset asserted mid-clear aborts the clear; all entries are still 0 because reset zeroes them.
- FSM states: IDLE and CLEAR.
  - IDLE -> CLEAR when clr=1.
  - CLEAR -> IDLE after the write to entry DEPTH-1.
- Write, IDLE only: if wr=1 and wr_addr < DEPTH, the entry is updated at the clock edge. Otherwise no entry changes and wr_err=1 in the next cycle.
- Read, IDLE only, latency 1:
  - If rd=1 and rd_addr < DEPTH: next cycle rd_valid=1, rd_err=0, rd_data = entry value.
  - If rd_addr >= DEPTH: next cycle rd_valid=1, rd_err=1, rd_data holds its previous value.
- rd=0: rd_valid=0 and rd_data holds.
- Simultaneous in-range rd and wr to the same address:
  - WRITE_FIRST=1: rd_data = wr_data.
  - WRITE_FIRST=0: rd_data = the pre-write value.
  - The entry is written in both cases.
- Different addresses are independent.
- clr in IDLE:
  - Starts the clear. That same cycle, rd and wr are serviced normally; clr has lower priority for that cycle only.
  - From the next cycle busy=1, and entry cnt is written to 0 each cycle, cnt = 0..DEPTH-1.
  - The clear takes exactly DEPTH cycles.
  - clr_done=1 and busy=0 in the cycle after the last write.
- During CLEAR (busy=1):
  - wr is ignored and wr_err pulses next cycle.
  - rd is rejected: next cycle rd_valid=1, rd_err=1, rd_data holds.
  - clr is ignored; there is no restart.
- DEPTH=1: the clear lasts 1 cycle.
- The counter width is sized for DEPTH-1 and never wraps past DEPTH-1.
- All outputs are registered; there are no combinational input-to-output paths.

Test Plan:
- Defaults. Reset, then read addresses 0..7 -> each gives rd_valid=1, rd_err=0, rd_data=0x00, one cycle after rd.
- Write 0xA5 to addr 3, 0x5A to addr 7, then read 3 and 7 -> rd_data 0xA5 then 0x5A, each 1 cycle after its request.
- Same-cycle wr 0x3C and rd, addr 2, which previously held 0x11:
  - WRITE_FIRST=1 -> rd_data=0x3C.
  - WRITE_FIRST=0 -> rd_data=0x11.
  - A following read returns 0x3C in both builds.
- Out of range (DEPTH=8): wr to addr 9 -> wr_err pulse, no entry changes. rd from addr 8 -> rd_valid=1, rd_err=1, rd_data unchanged.
- Clear with all entries 0xFF: pulse clr -> busy high for 8 cycles, then clr_done pulse and busy=0.
  - A wr issued mid-clear -> wr_err.
  - A rd issued mid-clear -> rd_err.
  - After the clear, all entries read 0x00.
- Async reset mid-clear: drop reset_n at clear cycle 3 -> busy=0 immediately, no clr_done pulse, all entries read 0. Repeat with DATA_WIDTH=16 and DEPTH=32 -> clear takes 32 cycles.
